cpu_bank_reg_mp: RTL and testbench

Parametrised multi-port register bank with a per-register scoreboard, the successor to the single-write-plus-multiplier-writeback register file in the decode/writeback path. It provides NUM_RD combinational read ports, NUM_WR prioritised write ports and optional same-cycle write-to-read bypass. It also tracks registers reserved by in-flight long-latency operations (mul/load) so that decode can stall on read-after-write hazards.

---
 rtl/cpu_bank_reg_pkg.sv | 17 +
 rtl/cpu_bank_reg_wr_arb.sv | 44 ++++
 rtl/cpu_bank_reg_mp.sv | 82 ++++++++
 tb/tb_cpu_bank_reg_mp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bank_reg_pkg.sv
// Shared constants and types for the multi-port register bank, also used by
// the decode and writeback stages.
package cpu_bank_reg_pkg;

  localparam int REG_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF  = 32;

  function automatic int addr_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

  localparam int AW_DEF = addr_width(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]        reg_addr_t;
  typedef logic [REG_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/cpu_bank_reg_wr_arb.sv
// Per-register write winner (highest enabled port index) and same-cycle
// address collision detect across all enabled write ports.
module cpu_bank_reg_wr_arb
  import cpu_bank_reg_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_WR    = 2,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr,
  input  logic [NUM_WR-1:0][REG_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]              win_en,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0] win_data,
  output logic                             collision
);

  // Ascending scan: a later (higher-index) match overwrites an earlier one.
  always_comb begin
    win_en   = '0;
    win_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p] == AW'(r))) begin
          win_en[r]   = 1'b1;
          win_data[r] = wr_data[p];
        end
      end
    end
  end

  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p] == wr_addr[q])) hit = 1'b1;
      end
    end
    collision = hit;
  end

endmodule

// File: rtl/cpu_bank_reg_mp.sv
// Multi-port register bank with prioritised writes, optional write-to-read
// bypass and a pending-writer scoreboard for long-latency destinations.
module cpu_bank_reg_mp
  import cpu_bank_reg_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG  = 1'b1,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_RD-1:0][AW-1:0]        rd_addr,
  output logic [NUM_RD-1:0][REG_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr,
  input  logic [NUM_WR-1:0][REG_WIDTH-1:0] wr_data,
  input  logic                             rsv_en,
  input  logic [AW-1:0]                    rsv_addr,
  input  logic                             flush,
  output logic [NUM_REGS-1:0]              pending,
  output logic                             wr_collision
);

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] reg_file;
  logic [NUM_REGS-1:0]                win_en;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] win_data;
  logic                               collision;

  cpu_bank_reg_wr_arb #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .NUM_WR    (NUM_WR)
  ) u_wr_arb (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .win_en    (win_en),
    .win_data  (win_data),
    .collision (collision)
  );

  // Reserve beats a same-cycle write so the in-flight op keeps ownership.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      reg_file     <= '0;
      pending      <= '0;
      wr_collision <= 1'b0;
    end else begin
      wr_collision <= collision;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (!(ZERO_REG && (r == 0))) begin
          if (win_en[r]) reg_file[r] <= win_data[r];
          if (flush)                                  pending[r] <= 1'b0;
          else if (rsv_en && (rsv_addr == AW'(r)))    pending[r] <= 1'b1;
          else if (win_en[r])                         pending[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!(ZERO_REG && (rd_addr[i] == '0))) begin
        if (BYPASS && win_en[rd_addr[i]]) begin
          rd_data[i] = win_data[rd_addr[i]];
          rd_busy[i] = 1'b0;
        end else begin
          rd_data[i] = reg_file[rd_addr[i]];
          rd_busy[i] = pending[rd_addr[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bank_reg_mp.sv
// Self-checking bench: two bank instances (bypass on/off) sharing stimulus,
// compared against a behavioural array model plus directed corner cases.
module tb_cpu_bank_reg_mp;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic                 clock;
  logic                 reset_n;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0]           wr_en;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][W-1:0]    wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 flush;

  logic [1:0][W-1:0]    rd_data, rd_data_nb;
  logic [1:0]           rd_busy, rd_busy_nb;
  logic [NR-1:0]        pending, pending_nb;
  logic                 coll, coll_nb;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_rf [NR];
  bit           m_pend [NR];
  bit           m_coll;

  cpu_bank_reg_mp #(.REG_WIDTH(W), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2),
                    .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .pending(pending),
    .wr_collision(coll));

  cpu_bank_reg_mp #(.REG_WIDTH(W), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2),
                    .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .pending(pending_nb),
    .wr_collision(coll_nb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit write_hits(input logic [AW-1:0] a);
    return (wr_en[0] && wr_addr[0] == a) || (wr_en[1] && wr_addr[1] == a);
  endfunction

  function automatic logic [W-1:0] exp_rd(input int i, input bit byp);
    logic [AW-1:0] a;
    a = rd_addr[i];
    if (a == 0) return '0;
    if (byp) begin
      if (wr_en[1] && wr_addr[1] == a) return wr_data[1];
      if (wr_en[0] && wr_addr[0] == a) return wr_data[0];
    end
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input int i, input bit byp);
    logic [AW-1:0] a;
    a = rd_addr[i];
    if (a == 0) return 1'b0;
    return m_pend[a] && !(byp && write_hits(a));
  endfunction

  function automatic logic [NR-1:0] exp_pend();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0; rd_addr = '0;
  endtask

  // Advance one clock and move the model to its post-edge state.
  task automatic tick();
    logic [W-1:0] n_rf [NR];
    bit           n_pend [NR];
    bit           n_coll;
    for (int r = 0; r < NR; r++) begin
      n_rf[r] = m_rf[r];
      n_pend[r] = m_pend[r];
    end
    n_coll = wr_en[0] && wr_en[1] && (wr_addr[0] == wr_addr[1]);
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p] != 0) n_rf[wr_addr[p]] = wr_data[p];
    for (int r = 1; r < NR; r++) begin
      if (flush) n_pend[r] = 1'b0;
      else if (rsv_en && rsv_addr == AW'(r)) n_pend[r] = 1'b1;
      else if (write_hits(AW'(r))) n_pend[r] = 1'b0;
    end
    if (!reset_n) begin
      for (int r = 0; r < NR; r++) begin
        n_rf[r] = '0;
        n_pend[r] = 1'b0;
      end
      n_coll = 1'b0;
    end
    @(posedge clock);
    for (int r = 0; r < NR; r++) begin
      m_rf[r] = n_rf[r];
      m_pend[r] = n_pend[r];
    end
    m_coll = n_coll;
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle();
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'hDEAD;
    tick();
    idle(); rd_addr[0] = 5; #1;
    n_vec++;
    if (rd_data_nb[0] !== 32'hDEAD) begin
      n_err++; $display("FAIL reset_pre_write: got %h want %h", rd_data_nb[0], 32'hDEAD);
    end
    reset_n = 1'b0;
    wr_en = 2'b11; wr_addr[0] = 5; wr_addr[1] = 5; wr_data[1] = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 8;
    tick();
    reset_n = 1'b1;
    idle(); rd_addr[0] = 5; rd_addr[1] = 8; #1;
    n_vec++;
    if (rd_data[0] !== '0 || rd_data_nb[0] !== '0) begin
      n_err++; $display("FAIL reset_data: got %h/%h want 0", rd_data[0], rd_data_nb[0]);
    end
    n_vec++;
    if (pending !== '0 || pending_nb !== '0 || rd_busy !== '0) begin
      n_err++; $display("FAIL reset_pending: got %h busy %b want 0", pending, rd_busy);
    end
    n_vec++;
    if (coll !== 1'b0) begin
      n_err++; $display("FAIL reset_collision: got %b want 0", coll);
    end
  endtask

  task automatic test_priority();
    idle();
    wr_en = 2'b11; wr_addr[0] = 3; wr_addr[1] = 3;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222;
    tick();
    idle(); rd_addr[0] = 3; #1;
    n_vec++;
    if (rd_data_nb[0] !== 32'h2222) begin
      n_err++; $display("FAIL priority_data: got %h want %h", rd_data_nb[0], 32'h2222);
    end
    n_vec++;
    if (coll !== 1'b1) begin
      n_err++; $display("FAIL collision_pulse: got %b want 1", coll);
    end
    tick(); #1;
    n_vec++;
    if (coll !== 1'b0) begin
      n_err++; $display("FAIL collision_clear: got %b want 0", coll);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 2'b01; wr_addr[0] = 7; wr_data[0] = 32'hCAFE; rd_addr[0] = 7; #1;
    n_vec++;
    if (rd_data[0] !== 32'hCAFE) begin
      n_err++; $display("FAIL bypass_on: got %h want %h", rd_data[0], 32'hCAFE);
    end
    n_vec++;
    if (rd_data_nb[0] !== 32'h0) begin
      n_err++; $display("FAIL bypass_off: got %h want 0", rd_data_nb[0]);
    end
    tick();
    idle(); rd_addr[1] = 7; #1;
    n_vec++;
    if (rd_data_nb[1] !== 32'hCAFE) begin
      n_err++; $display("FAIL bypass_off_next: got %h want %h", rd_data_nb[1], 32'hCAFE);
    end
  endtask

  task automatic test_scoreboard();
    idle(); rsv_en = 1'b1; rsv_addr = 9;
    tick();
    idle(); rd_addr[0] = 9; #1;
    n_vec++;
    if (rd_busy[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1 || pending[9] !== 1'b1) begin
      n_err++; $display("FAIL reserve_busy: got %b/%b pend %b want 1", rd_busy[0], rd_busy_nb[0], pending[9]);
    end
    wr_en = 2'b10; wr_addr[1] = 9; wr_data[1] = 32'h42; #1;
    n_vec++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h42) begin
      n_err++; $display("FAIL clear_bypass: busy %b data %h want 0/42", rd_busy[0], rd_data[0]);
    end
    n_vec++;
    if (rd_busy_nb[0] !== 1'b1) begin
      n_err++; $display("FAIL clear_nobypass_same: got %b want 1", rd_busy_nb[0]);
    end
    tick();
    idle(); rd_addr[0] = 9; #1;
    n_vec++;
    if (pending[9] !== 1'b0 || rd_busy_nb[0] !== 1'b0) begin
      n_err++; $display("FAIL clear_next: pend %b busy %b want 0", pending[9], rd_busy_nb[0]);
    end
  endtask

  task automatic test_races();
    idle(); rsv_en = 1'b1; rsv_addr = 4;
    wr_en = 2'b10; wr_addr[1] = 4; wr_data[1] = 32'h55;
    tick();
    idle(); #1;
    n_vec++;
    if (pending[4] !== 1'b1) begin
      n_err++; $display("FAIL reserve_wins: got %b want 1", pending[4]);
    end
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 6;
    tick();
    idle(); #1;
    n_vec++;
    if (pending !== '0 || pending_nb !== '0) begin
      n_err++; $display("FAIL flush_clear: got %h want 0", pending);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 2'b01; wr_addr[0] = 0; wr_data[0] = 32'hFFFF;
    rsv_en = 1'b1; rsv_addr = 0; #1;
    n_vec++;
    if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL zero_same: data %h busy %b want 0", rd_data[0], rd_busy[0]);
    end
    tick();
    idle(); #1;
    n_vec++;
    if (rd_data[0] !== '0 || rd_data_nb[0] !== '0 || rd_busy !== '0 || pending[0] !== 1'b0) begin
      n_err++; $display("FAIL zero_next: data %h busy %b pend0 %b want 0", rd_data_nb[0], rd_busy, pending[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      wr_en = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        wr_addr[p] = AW'($urandom_range(0, 7));
        wr_data[p] = $urandom;
        rd_addr[p] = AW'($urandom_range(0, 7));
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (rd_data[i] !== exp_rd(i, 1'b1) || rd_data_nb[i] !== exp_rd(i, 1'b0)) begin
          n_err++; $display("FAIL rand_rd%0d n=%0d: got %h/%h want %h/%h", i, n,
                            rd_data[i], rd_data_nb[i], exp_rd(i, 1'b1), exp_rd(i, 1'b0));
        end
        n_vec++;
        if (rd_busy[i] !== exp_busy(i, 1'b1) || rd_busy_nb[i] !== exp_busy(i, 1'b0)) begin
          n_err++; $display("FAIL rand_busy%0d n=%0d: got %b/%b want %b/%b", i, n,
                            rd_busy[i], rd_busy_nb[i], exp_busy(i, 1'b1), exp_busy(i, 1'b0));
        end
      end
      n_vec++;
      if (pending !== exp_pend() || pending_nb !== exp_pend()) begin
        n_err++; $display("FAIL rand_pending n=%0d: got %h/%h want %h", n, pending, pending_nb, exp_pend());
      end
      n_vec++;
      if (coll !== m_coll || coll_nb !== m_coll) begin
        n_err++; $display("FAIL rand_collision n=%0d: got %b/%b want %b", n, coll, coll_nb, m_coll);
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      m_rf[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_coll = 1'b0;
    reset_n = 1'b0;
    idle();
    @(negedge clock);
    tick();
    tick();
    reset_n = 1'b1;
    test_reset();
    test_priority();
    test_bypass();
    test_scoreboard();
    test_races();
    test_zero_reg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
